// File: rtl/codec_pkg.sv
// codec_pkg: constants and types shared by the codec serial transmitter and
// receiver.
//   ARRAY_SIZE      - sample width in bits
//   SHIFT_REG       - sclk slots per lrck half-frame
//   FIRST_DATA_SLOT - first slot carrying sample data (slot 0 is the I2S delay bit)
//   LAST_DATA_SLOT  - slot carrying the sample LSB
//   rx_state_t      - receive deserializer FSM states
package codec_pkg;

    localparam int ARRAY_SIZE      = 20;
    localparam int SHIFT_REG       = 32;
    localparam int FIRST_DATA_SLOT = 1;
    localparam int LAST_DATA_SLOT  = ARRAY_SIZE;

    typedef enum logic [2:0] {
        SYNC,
        SHIFT_L,
        WAIT_L,
        SHIFT_R,
        WAIT_R
    } rx_state_t;

endpackage

// File: rtl/codec_sync_edge.sv
// codec_sync_edge: N-stage synchronizer for an asynchronous single-bit input,
// with one-clock rise/fall pulses derived from the synchronized value.
//   clock  - fabric clock
//   reset  - asynchronous active-low reset
//   din    - asynchronous input
//   sync   - synchronized copy of din
//   rise   - one-clock pulse on a synchronized 0->1 transition
//   fall   - one-clock pulse on a synchronized 1->0 transition
module codec_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/codec_rx_deserializer.sv
// codec_rx_deserializer: oversamples the codec I2S bus (sclk, lrck, sdout) in
// the fabric clock domain and delivers left/right samples as a coherent pair.
//   clock            - fabric clock, at least 4x sclk
//   reset            - asynchronous active-low reset
//   sclk/lrck/sdout  - codec bit clock, word clock (0 = left), serial data
//   l_codec_to_fpga  - last complete left sample
//   r_codec_to_fpga  - last complete right sample
//   sample_valid     - one-clock pulse when a new pair is loaded
//   frame_error      - one-clock pulse on a short or over-long half-frame
//   locked           - high once aligned to a left half-frame start
module codec_rx_deserializer #(
    parameter int ARRAY_SIZE  = codec_pkg::ARRAY_SIZE,
    parameter int SHIFT_REG   = codec_pkg::SHIFT_REG,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrck,
    input  logic                  sdout,
    output logic [ARRAY_SIZE-1:0] l_codec_to_fpga,
    output logic [ARRAY_SIZE-1:0] r_codec_to_fpga,
    output logic                  sample_valid,
    output logic                  frame_error,
    output logic                  locked
);

    import codec_pkg::*;

    localparam int               CNT_W   = $clog2(SHIFT_REG);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_REG - 1);
    localparam logic [CNT_W-1:0] FIRST   = CNT_W'(FIRST_DATA_SLOT);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FIRST_DATA_SLOT + ARRAY_SIZE - 1);

    logic sclk_s, rise_evt, lrck_s, sdout_s;
    logic sclk_fall_unused, lrck_rise_unused, lrck_fall_unused;

    codec_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clock (clock),
        .reset (reset),
        .din   (sclk),
        .sync  (sclk_s),
        .rise  (rise_evt),
        .fall  (sclk_fall_unused)
    );

    codec_sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clock (clock),
        .reset (reset),
        .din   (lrck),
        .sync  (lrck_s),
        .rise  (lrck_rise_unused),
        .fall  (lrck_fall_unused)
    );

    // Same depth as the sclk chain so the data bit seen on rise_evt is the
    // one present at the sclk edge.
    logic [SYNC_STAGES-1:0] sd_chain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sd_chain <= '0;
        else        sd_chain <= {sd_chain[SYNC_STAGES-2:0], sdout};
    end

    assign sdout_s = sd_chain[SYNC_STAGES-1];

    rx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;     // slot index of the previous rise_evt
    logic                  lr_prev;     // lrck as sampled at the previous rise_evt
    logic [ARRAY_SIZE-1:0] shreg;
    logic [ARRAY_SIZE-1:0] left_hold;
    logic                  load_pend;

    logic                  lr_chg, in_data, overlong;
    logic [CNT_W-1:0]      slot;
    logic [ARRAY_SIZE-1:0] shreg_nxt;

    // An lrck change on the same rise makes that rise slot 0 of the new half.
    assign lr_chg    = lrck_s != lr_prev;
    assign slot      = lr_chg ? '0 : bit_cnt + 1'b1;
    assign in_data   = (slot >= FIRST) && (slot <= LAST);
    assign overlong  = !lr_chg && (bit_cnt == CNT_MAX);
    assign shreg_nxt = {shreg[ARRAY_SIZE-2:0], sdout_s};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= SYNC;
            bit_cnt         <= '0;
            lr_prev         <= 1'b0;
            shreg           <= '0;
            left_hold       <= '0;
            load_pend       <= 1'b0;
            l_codec_to_fpga <= '0;
            r_codec_to_fpga <= '0;
            sample_valid    <= 1'b0;
            frame_error     <= 1'b0;
            locked          <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            load_pend    <= 1'b0;

            // Right word landed in shreg on the previous clock; rise events
            // are at least 4 clocks apart so shreg is still intact here.
            if (load_pend) begin
                l_codec_to_fpga <= left_hold;
                r_codec_to_fpga <= shreg;
                sample_valid    <= 1'b1;
            end

            if (rise_evt) begin
                if (lr_chg) begin
                    bit_cnt <= '0;
                    lr_prev <= lrck_s;
                end else if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end

                case (state)
                    SYNC: begin
                        if (lr_chg && !lrck_s) begin
                            state  <= SHIFT_L;
                            locked <= 1'b1;
                        end
                    end

                    SHIFT_L, SHIFT_R: begin
                        if (lr_chg) begin
                            // Short half-frame: drop everything partial.
                            frame_error <= 1'b1;
                            shreg       <= '0;
                            left_hold   <= '0;
                            if (!lrck_s) begin
                                state <= SHIFT_L;
                            end else begin
                                state  <= SYNC;
                                locked <= 1'b0;
                            end
                        end else if (in_data) begin
                            shreg <= shreg_nxt;
                            if (slot == LAST) begin
                                if (state == SHIFT_L) begin
                                    left_hold <= shreg_nxt;
                                    state     <= WAIT_L;
                                end else begin
                                    load_pend <= 1'b1;
                                    state     <= WAIT_R;
                                end
                            end
                        end
                    end

                    WAIT_L, WAIT_R: begin
                        if (lr_chg) begin
                            state <= (state == WAIT_L) ? SHIFT_R : SHIFT_L;
                        end else if (overlong) begin
                            frame_error <= 1'b1;
                            state       <= SYNC;
                            locked      <= 1'b0;
                        end
                    end

                    default: begin
                        state  <= SYNC;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
